// File: rtl/barrel_shifter_pkg.sv
// ============================================================================
// Module      : barrel_shifter_pkg
// Description : Shared widths and direction encodings for the shift unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package barrel_shifter_pkg;

    localparam int DATA_W = 32;
    localparam int AMT_W  = 5;

    localparam logic SH_LEFT  = 1'b0;
    localparam logic SH_RIGHT = 1'b1;

endpackage : barrel_shifter_pkg

`default_nettype wire

// File: rtl/barrel_shifter_shift_stage.sv
// ============================================================================
// Module      : shift_stage
// Description : One fixed-distance stage of the logarithmic shift network.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_stage
    import barrel_shifter_pkg::SH_RIGHT;
#(
    parameter int DATA_W = 32,
    parameter int DIST   = 1
) (
    input  logic              enable_i,
    input  logic              dir_i,
    input  logic              fill_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    // Right shifts pull in the fill bit, left shifts pull in zeros.
    always_comb begin
        data_o = data_i;
        if (enable_i) begin
            if (dir_i == SH_RIGHT) begin
                data_o = {{DIST{fill_i}}, data_i[DATA_W-1:DIST]};
            end else begin
                data_o = {data_i[DATA_W-1-DIST:0], {DIST{1'b0}}};
            end
        end
    end

endmodule : shift_stage

`default_nettype wire

// File: rtl/barrel_shifter.sv
// ============================================================================
// Module      : barrel_shifter
// Description : 32-bit logical-left / arithmetic-right shifter, registered out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module barrel_shifter #(
    parameter int DATA_W = barrel_shifter_pkg::DATA_W,
    parameter int AMT_W  = barrel_shifter_pkg::AMT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              SH_DIR,
    input  logic [AMT_W-1:0]  SH_AMT,
    input  logic [DATA_W-1:0] D_IN,
    output logic [DATA_W-1:0] D_OUT
);

    logic [DATA_W-1:0] w_stage [0:AMT_W];
    logic              w_fill;
    logic [DATA_W-1:0] w_dout_d;
    logic [DATA_W-1:0] r_dout_q;

    // Sign comes from the original operand so every stage fills consistently.
    assign w_fill     = D_IN[DATA_W-1];
    assign w_stage[0] = D_IN;

    // Largest distance first: stage gi handles SH_AMT bit AMT_W-1-gi.
    generate
        for (genvar gi = 0; gi < AMT_W; gi++) begin : g_stage
            shift_stage #(
                .DATA_W (DATA_W),
                .DIST   (1 << (AMT_W - 1 - gi))
            ) u_stage (
                .enable_i (SH_AMT[AMT_W-1-gi]),
                .dir_i    (SH_DIR),
                .fill_i   (w_fill),
                .data_i   (w_stage[gi]),
                .data_o   (w_stage[gi+1])
            );
        end
    endgenerate

    assign w_dout_d = w_stage[AMT_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_dout_q <= '0;
        end else begin
            r_dout_q <= w_dout_d;
        end
    end

    assign D_OUT = r_dout_q;

endmodule : barrel_shifter

`default_nettype wire

// File: tb/tb_barrel_shifter.sv
// ============================================================================
// Module      : tb_barrel_shifter
// Description : Directed and pipelined checks of the registered barrel shifter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_barrel_shifter;

    logic        clk = 1'b0;
    logic        reset;
    logic        sh_dir;
    logic [4:0]  sh_amt;
    logic [31:0] d_in;
    logic [31:0] d_out;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    barrel_shifter dut (
        .clk    (clk),
        .reset  (reset),
        .SH_DIR (sh_dir),
        .SH_AMT (sh_amt),
        .D_IN   (d_in),
        .D_OUT  (d_out)
    );

    function automatic logic [31:0] ref_shift(input logic dir, input logic [4:0] amt,
                                              input logic [31:0] x);
        logic [31:0] r;
        r = x;
        for (int i = 0; i < int'(amt); i++) begin
            if (dir) r = {r[31], r[31:1]};
            else     r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; sh_dir = 1'b0; sh_amt = 5'd3; d_in = 32'hFFFF_FFFF;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (d_out !== 32'h0) begin
                n_err++;
                $display("FAIL reset_hold cyc=%0d got=%h exp=%h", i, d_out, 32'h0);
            end
        end
        reset = 1'b0;
        step();
        n_cmp++;
        if (d_out !== 32'hFFFF_FFF8) begin
            n_err++;
            $display("FAIL reset_release got=%h exp=%h", d_out, 32'hFFFF_FFF8);
        end
    endtask

    task automatic test_right_neg();
        logic [31:0] exp;
        sh_dir = 1'b1; d_in = 32'h8000_0000;
        for (int a = 0; a < 32; a++) begin
            sh_amt = 5'(a);
            exp = ~(32'hFFFF_FFFF >> (a + 1));
            step();
            n_cmp++;
            if (d_out !== exp) begin
                n_err++;
                $display("FAIL right_neg amt=%0d got=%h exp=%h", a, d_out, exp);
            end
            if (a == 4 || a == 31) begin
                exp = (a == 4) ? 32'hF800_0000 : 32'hFFFF_FFFF;
                n_cmp++;
                if (d_out !== exp) begin
                    n_err++;
                    $display("FAIL right_neg_pt amt=%0d got=%h exp=%h", a, d_out, exp);
                end
            end
        end
    endtask

    task automatic test_right_pos();
        logic [31:0] exp;
        sh_dir = 1'b1; d_in = 32'h4000_0000;
        for (int a = 0; a < 32; a++) begin
            sh_amt = 5'(a);
            exp = 32'h4000_0000 >> a;
            step();
            n_cmp++;
            if (d_out !== exp) begin
                n_err++;
                $display("FAIL right_pos amt=%0d got=%h exp=%h", a, d_out, exp);
            end
        end
        sh_amt = 5'd30; step();
        n_cmp++;
        if (d_out !== 32'h1) begin
            n_err++;
            $display("FAIL right_pos_30 got=%h exp=%h", d_out, 32'h1);
        end
    endtask

    task automatic test_left();
        logic [31:0] exp;
        sh_dir = 1'b0; d_in = 32'h0000_0001;
        for (int a = 0; a < 32; a++) begin
            sh_amt = 5'(a);
            exp = 32'h1 << a;
            step();
            n_cmp++;
            if (d_out !== exp) begin
                n_err++;
                $display("FAIL left amt=%0d got=%h exp=%h", a, d_out, exp);
            end
        end
        n_cmp++;
        if (d_out !== 32'h8000_0000) begin
            n_err++;
            $display("FAIL left_31 got=%h exp=%h", d_out, 32'h8000_0000);
        end
    endtask

    task automatic test_pattern();
        logic        dirs [4];
        logic [4:0]  amts [4];
        logic [31:0] exps [4];
        dirs = '{1'b0, 1'b1, 1'b0, 1'b1};
        amts = '{5'd0, 5'd0, 5'd4, 5'd4};
        exps = '{32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h5A5A_5A50, 32'hFA5A_5A5A};
        d_in = 32'hA5A5_A5A5;
        for (int i = 0; i < 4; i++) begin
            sh_dir = dirs[i]; sh_amt = amts[i];
            step();
            n_cmp++;
            if (d_out !== exps[i]) begin
                n_err++;
                $display("FAIL pattern dir=%0b amt=%0d got=%h exp=%h",
                         dirs[i], amts[i], d_out, exps[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        for (int i = 0; i < 40; i++) begin
            sh_dir = 1'($urandom);
            sh_amt = 5'($urandom_range(0, 31));
            d_in   = $urandom;
            reset  = (i == 20);
            exp    = reset ? 32'h0 : ref_shift(sh_dir, sh_amt, d_in);
            step();
            n_cmp++;
            if (d_out !== exp) begin
                n_err++;
                $display("FAIL pipe i=%0d dir=%0b amt=%0d din=%h got=%h exp=%h",
                         i, sh_dir, sh_amt, d_in, d_out, exp);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; sh_dir = 1'b0; sh_amt = '0; d_in = '0;
        test_reset();
        test_right_neg();
        test_right_pos();
        test_left();
        test_pattern();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_barrel_shifter

`default_nettype wire
